// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register feeding the 64-bit ALU: decodes the ALU control code,
// selects operand B, and supports stall, flush, illegal-op marking and bubble counting.
module id_ex_alu_issue #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       aluop_main,
  input  logic [2:0]       funct3,
  input  logic             funct7_b5,
  input  logic             alusrc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [4:0]       rd_in,
  input  logic             regwrite_in,
  input  logic             memread_in,
  input  logic             memwrite_in,
  input  logic             memtoreg_in,
  input  logic             branch_in,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_a,
  output logic [XLEN-1:0]  ex_b,
  output logic [3:0]       ex_alu_ctrl,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [4:0]       ex_rd,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_branch,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]      dec_ctrl;
  logic            dec_illegal;
  logic [XLEN-1:0] opb;
  logic            load_bubble;
  logic            next_valid;

  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_illegal = 1'b0;
    case (aluop_main)
      2'b00: dec_ctrl = ALU_ADD;
      2'b01: dec_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  dec_ctrl = (aluop_main == 2'b10 && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b111:  dec_ctrl = ALU_AND;
          3'b110:  dec_ctrl = ALU_OR;
          3'b010:  dec_ctrl = ALU_SLT;
          default: dec_illegal = 1'b1;
        endcase
        // funct7[5] only distinguishes ADD/SUB; on any other R-type op it is an invalid encoding
        if (aluop_main == 2'b10 && funct7_b5 && funct3 != 3'b000) dec_illegal = 1'b1;
        if (dec_illegal) dec_ctrl = ALU_AND;
      end
    endcase
  end

  assign opb         = alusrc ? imm : rs2_data;
  assign load_bubble = flush | (~stall & ~id_valid);
  assign next_valid  = flush ? 1'b0 : (stall ? ex_valid : id_valid);

  // Valid semantics: ex_valid=1 means EX holds a real instruction; there is no
  // backpressure, so stall freezes the register and flush overrides stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || load_bubble) begin
      ex_valid      <= 1'b0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_alu_ctrl   <= ALU_AND;
      ex_store_data <= '0;
      ex_rd         <= '0;
      ex_regwrite   <= 1'b0;
      ex_memread    <= 1'b0;
      ex_memwrite   <= 1'b0;
      ex_memtoreg   <= 1'b0;
      ex_branch     <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= 1'b1;
      ex_a          <= rs1_data;
      ex_b          <= opb;
      ex_alu_ctrl   <= dec_ctrl;
      ex_store_data <= rs2_data;
      ex_rd         <= rd_in;
      ex_regwrite   <= regwrite_in & ~dec_illegal;
      ex_memread    <= memread_in & ~dec_illegal;
      ex_memwrite   <= memwrite_in & ~dec_illegal;
      ex_memtoreg   <= memtoreg_in;
      ex_branch     <= branch_in;
      ex_illegal    <= dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (!next_valid && bubble_count != CNT_MAX) begin
      bubble_count <= bubble_count + CNT_ONE;
    end
  end

endmodule
